// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_HOLD_W = 8;

endpackage

// File: rtl/ps8.sv
// 8-input priority selector: highest-index set request wins, output one-hot.
module ps8 (
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o
);

  // higher[k] is set when any request above bit k is present
  logic [7:0] higher;

  assign higher[7] = 1'b0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sel
    if (gi < 7) begin : g_chain
      assign higher[gi] = higher[gi+1] | req_i[gi+1];
    end
    assign gnt_o[gi] = en_i & req_i[gi] & ~higher[gi];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded tenure, explicit release and one bubble
// cycle between consecutive grants.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0]         PTR_MAX   = IW'(N - 1);
  localparam logic [ARB_HOLD_W-1:0] HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

  arb_state_t            state_q, state_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [ARB_HOLD_W-1:0] hold_q, hold_d;
  logic                  rdy_q;

  logic [IW-1:0] shift;
  logic [N-1:0]  rot_req;
  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic [7:0]    ps_req;
  logic [7:0]    ps_gnt;
  logic          hold_ok;

  // Rotate so that bit ptr lands on the selector's top-priority input.
  assign shift = PTR_MAX - ptr_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_req[gi] = req_i[IW'(gi) - shift];
    assign win[gi]     = ps_gnt[IW'(gi) + shift];
  end

  assign ps_req = 8'(rot_req);

  ps8 u_ps8 (
    .en_i  (1'b1),
    .req_i (ps_req),
    .gnt_o (ps_gnt)
  );

  if (N < 8) begin : g_unused
    logic unused_ps_gnt;
    assign unused_ps_gnt = |ps_gnt[7:N];
  end

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (win[k]) win_idx = win_idx | IW'(k);
    end
  end

  always_comb begin
    gnt_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) gnt_idx_o = gnt_idx_o | IW'(k);
    end
  end

  assign hold_ok = (|(gnt_q & req_i)) && !(|(gnt_q & done_i)) && en_i
                   && (hold_q < HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        // rdy_q keeps the first edge after reset free of grants
        if (rdy_q && en_i && (|req_i)) begin
          state_d = GRANT;
          gnt_d   = win;
          ptr_d   = win_idx - IW'(1);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (hold_q < HOLD_LAST) hold_d = hold_q + ARB_HOLD_W'(1);
        if (!hold_ok) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_MAX;
      hold_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      rdy_q   <= 1'b1;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=8, MAX_HOLD=16): vector table plus
// hand-written multi-cycle sequences, checked through a scoreboard queue.
module tb_rr_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] gnt;
    logic       busy;
    string      tag;
  } exp_t;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) if (g[k]) r = 3'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic e, input logic [7:0] r, input logic [7:0] d,
                      input logic [7:0] eg, input string tag);
    exp_t ex;
    en   = e;
    req  = r;
    done = d;
    sb_q.push_back('{gnt: eg, busy: |eg, tag: tag});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      ex = sb_q.pop_front();
      $display("%s en=%0b req=%h done=%h gnt=%h idx=%0d busy=%0b", ex.tag, e, r, d, gnt, gnt_idx, busy);
      chk({ex.tag, "_gnt"}, 32'(gnt), 32'(ex.gnt));
      chk({ex.tag, "_idx"}, 32'(gnt_idx), 32'(idx_of(ex.gnt)));
      chk({ex.tag, "_busy"}, 32'(busy), 32'(ex.busy));
    end
  endtask

  task automatic do_reset();
    en   = 1'b0;
    req  = '0;
    done = '0;
    rst  = 1'b1;
    #2;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;

    vecs[0]  = '{1'b1, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 8'h81, 8'h00, 8'h80};
    vecs[2]  = '{1'b1, 8'h81, 8'h80, 8'h00};
    vecs[3]  = '{1'b1, 8'h81, 8'h00, 8'h01};
    vecs[4]  = '{1'b1, 8'h01, 8'h01, 8'h00};
    vecs[5]  = '{1'b1, 8'h08, 8'h00, 8'h08};
    vecs[6]  = '{1'b1, 8'h48, 8'h20, 8'h08};
    vecs[7]  = '{1'b1, 8'h08, 8'h20, 8'h08};
    vecs[8]  = '{1'b1, 8'h48, 8'h20, 8'h08};
    vecs[9]  = '{1'b0, 8'h08, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 8'h60, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 8'h60, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 8'h60, 8'h00, 8'h40};
    vecs[13] = '{1'b1, 8'h60, 8'h40, 8'h00};
    vecs[14] = '{1'b1, 8'h60, 8'h00, 8'h20};
    vecs[15] = '{1'b0, 8'h20, 8'h20, 8'h00};
    vecs[16] = '{1'b0, 8'h20, 8'h00, 8'h00};
    vecs[17] = '{1'b1, 8'h00, 8'h00, 8'h00};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].en, vecs[i].req, vecs[i].done, vecs[i].gnt, $sformatf("vec%0d", i));
    end

    // No grant on the first edge after reset, even with requests pending.
    do_reset();
    step(1'b1, 8'h81, 8'h00, 8'h00, "post_reset_edge1");
    step(1'b1, 8'h81, 8'h00, 8'h80, "post_reset_edge2");

    // All requesting, no releases: full MAX_HOLD tenures in rotation.
    do_reset();
    step(1'b1, 8'hFF, 8'h00, 8'h00, "rot_rdy");
    for (int o = 0; o < 9; o++) begin
      g = 8'b1 << (7 - (o % 8));
      for (int c = 0; c < MAX_HOLD; c++) begin
        step(1'b1, 8'hFF, 8'h00, g, $sformatf("rot_t%0d_c%0d", o, c));
      end
      if (o < 8) step(1'b1, 8'hFF, 8'h00, 8'h00, $sformatf("rot_bubble%0d", o));
    end

    // Single persistent requester is re-granted after each bubble.
    do_reset();
    step(1'b1, 8'h04, 8'h00, 8'h00, "single_rdy");
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step(1'b1, 8'h04, 8'h00, 8'h04, $sformatf("single_t%0d_c%0d", t, c));
      end
      step(1'b1, 8'h04, 8'h00, 8'h00, $sformatf("single_bubble%0d", t));
    end

    // Reset pulsed between edges mid-tenure clears the grant at once.
    do_reset();
    step(1'b1, 8'h08, 8'h00, 8'h00, "midrst_rdy");
    step(1'b1, 8'h08, 8'h00, 8'h08, "midrst_grant");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_async_gnt", 32'(gnt), 32'd0);
    chk("midrst_async_busy", 32'(busy), 32'd0);
    chk("midrst_async_idx", 32'(gnt_idx), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_after_gnt", 32'(gnt), 32'd0);
    step(1'b1, 8'h18, 8'h00, 8'h00, "midrst_req_edge1");
    step(1'b1, 8'h18, 8'h00, 8'h10, "midrst_req_edge2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 8: number of requesters; legal values 2, 4, 8.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  arbitration enable; low blocks new grants and ends any current tenure.
REQ-006 req  input  N  request vector, one bit per requester.
REQ-007 done  input  N  release strobe, one bit per requester; only the bit of the current holder is observed.
REQ-008 gnt  output  N  registered one-hot grant vector, or all zero.
REQ-009 gnt_idx  output  $clog2(N)  index of the granted requester; 0 when gnt is zero.
REQ-010 busy  output  1  high exactly when the FSM is in GRANT.

Function
REQ-011 The FSM SHALL have two states, IDLE and GRANT; gnt is nonzero only in GRANT.
REQ-012 IDLE, en=1 and |req=1: select the winner, then at the next edge load gnt with that one-hot bit and enter GRANT.
- Latency from sampled req to visible gnt: 1 cycle.
REQ-013 IDLE, en=0 or req=0: stay in IDLE with gnt=0.
REQ-014 Winner selection SHALL scan descending from pointer ptr with wrap: ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set req bit wins.
REQ-015 On each grant to index i, ptr SHALL update to (i-1) mod N, so that i becomes lowest priority.
REQ-016 In GRANT, gnt SHALL hold while all of the following are true: req[i]=1, done[i]=0, en=1, and hold_cnt < MAX_HOLD-1.
REQ-017 In GRANT, if any hold condition fails, the next edge SHALL clear gnt and enter IDLE.
- This gives one mandatory bubble cycle before the next grant.
REQ-018 hold_cnt SHALL be 8 bits, reset to 0 on each grant, and increment once per GRANT cycle.
- It saturates at MAX_HOLD-1 and never wraps.
- A tenure therefore lasts at most MAX_HOLD cycles.
REQ-019 done bits of non-holders and req changes of non-holders SHALL have no effect during GRANT.
REQ-020 Simultaneous done[i]=1 and req[i]=0 SHALL count as a single release.
REQ-021 If en falls in the same cycle that a release condition occurs, the result SHALL be a single release and no new grant while en=0.
REQ-022 With a single requester continuously asserting req, that requester SHALL be re-granted after each bubble.

Reset
REQ-023 While reset is high, asynchronously: state=IDLE, gnt=0, gnt_idx=0, busy=0, hold_cnt=0, ptr=N-1.
- With ptr=N-1, the first arbitration after reset matches fixed highest-index priority.
REQ-024 Reset asserted mid-tenure SHALL clear gnt immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the first grant SHALL appear no earlier than the second rising edge.

Structure
REQ-026 A shared package arb_pkg SHALL hold:
- the state enum type arb_state_t {IDLE, GRANT};
- the constant ARB_HOLD_W = 8.
REQ-027 Winner selection SHALL reuse the existing priority selector ps8, with en tied to 1.
- Input: req rotated left by (N-1-ptr).
- Output: rotated back before registering.
- For N<8, tie the unused upper inputs to 0.
REQ-028 gnt_idx SHALL be derived from the registered gnt by one-hot-to-binary conversion, with no extra register.

Verification
REQ-029 After reset, en=1, req=8'b0000_0000 then 8'b1000_0001 -> next edge gnt=8'b1000_0000, gnt_idx=7, busy=1.
REQ-030 Holder 7 pulses done[7] -> next edge gnt=0; following edge gnt=8'b0000_0001, gnt_idx=0 (rotation).
REQ-031 req=8'hFF held, done never asserted, MAX_HOLD=16:
- each grant lasts exactly 16 cycles, then one idle cycle;
- grant order is 7,6,5,4,3,2,1,0,7.
REQ-032 During a tenure on requester 3, done[5]=1 and req[6] toggles -> gnt stays 8'b0000_1000.
REQ-033 en=0 while holding -> next edge gnt=0. With req=8'b0110_0000 and en still 0 -> gnt remains 0. Raising en -> grant to the next index in rotation.
REQ-034 Reset pulsed mid-tenure (between clock edges) -> gnt=0 immediately, ptr=N-1. Then req=8'b0001_1000 -> gnt=8'b0001_0000.
